// File: rtl/countdown_timer.sv
// Purpose : microwave M:SS countdown; shifts BCD keypad digits in while idle, counts down on the 1 Hz tick while running.
// Latency : one core clock from input edge (load/stop/tick) or startn level to the registered digit/state outputs.
// Backpress: none; the keypad encoder is throttled through keypad_enablen, which is low only in ENTRY.
// Ports   : clk, clearn (async active-low reset), bcd_in/loadn (digit + falling-edge strobe),
//           startn (level), stopn (falling edge), pgt_1hz (rising edge = tick),
//           sec_ones/sec_tens/min_ones (display digits), keypad_enablen, magnetron_on, done.
module countdown_timer #(
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               clearn,
  input  logic [DIGIT_W-1:0] bcd_in,
  input  logic               loadn,
  input  logic               startn,
  input  logic               stopn,
  input  logic               pgt_1hz,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic               keypad_enablen,
  output logic               magnetron_on,
  output logic               done
);

  localparam logic [1:0] ST_ENTRY = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [DIGIT_W-1:0] D_ZERO = '0;
  localparam logic [DIGIT_W-1:0] D_NINE = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] D_FIVE = DIGIT_W'(5);
  localparam logic [DIGIT_W-1:0] D_ONE  = DIGIT_W'(1);

  logic [1:0] state, state_nxt;
  logic [DIGIT_W-1:0] so_nxt, st_nxt, mo_nxt;
  logic [DIGIT_W-1:0] dec_so, dec_st, dec_mo;
  logic loadn_q, stopn_q, pgt_q;
  logic load_fall, stop_fall, tick;
  logic time_nz, dec_zero;

  // Edge registers preset high so idle-high inputs (and pgt_1hz already
  // high at reset release) produce no phantom event.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      loadn_q <= 1'b1;
      stopn_q <= 1'b1;
      pgt_q   <= 1'b1;
    end else begin
      loadn_q <= loadn;
      stopn_q <= stopn;
      pgt_q   <= pgt_1hz;
    end
  end

  assign load_fall = loadn_q & ~loadn;
  assign stop_fall = stopn_q & ~stopn;
  assign tick      = ~pgt_q & pgt_1hz;

  assign time_nz = (sec_ones != D_ZERO) || (sec_tens != D_ZERO) || (min_ones != D_ZERO);

  // Plain BCD borrow chain. Tens above 5 are not normalised; they simply
  // count down. RUN is only entered with a nonzero time, so minutes never
  // underflow.
  always_comb begin
    dec_so = sec_ones;
    dec_st = sec_tens;
    dec_mo = min_ones;
    if (sec_ones != D_ZERO) begin
      dec_so = sec_ones - D_ONE;
    end else if (sec_tens != D_ZERO) begin
      dec_so = D_NINE;
      dec_st = sec_tens - D_ONE;
    end else begin
      dec_so = D_NINE;
      dec_st = D_FIVE;
      dec_mo = min_ones - D_ONE;
    end
  end

  assign dec_zero = (dec_so == D_ZERO) && (dec_st == D_ZERO) && (dec_mo == D_ZERO);

  // Event priority in every state: stop_fall, then startn, then tick/load.
  always_comb begin
    state_nxt = state;
    so_nxt    = sec_ones;
    st_nxt    = sec_tens;
    mo_nxt    = min_ones;
    case (state)
      ST_ENTRY: begin
        if (stop_fall) begin
          so_nxt = D_ZERO;
          st_nxt = D_ZERO;
          mo_nxt = D_ZERO;
        end else if (!startn && time_nz) begin
          state_nxt = ST_RUN;
        end else if (load_fall && (bcd_in <= D_NINE)) begin
          mo_nxt = sec_tens;
          st_nxt = sec_ones;
          so_nxt = bcd_in;
        end
      end
      ST_RUN: begin
        if (stop_fall) begin
          state_nxt = ST_PAUSE;
        end else if (tick) begin
          so_nxt = dec_so;
          st_nxt = dec_st;
          mo_nxt = dec_mo;
          if (dec_zero) state_nxt = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (stop_fall) begin
          state_nxt = ST_ENTRY;
          so_nxt    = D_ZERO;
          st_nxt    = D_ZERO;
          mo_nxt    = D_ZERO;
        end else if (!startn) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        if (stop_fall || !startn) state_nxt = ST_ENTRY;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they flip on the
  // same edge as the state register.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state          <= ST_ENTRY;
      sec_ones       <= D_ZERO;
      sec_tens       <= D_ZERO;
      min_ones       <= D_ZERO;
      keypad_enablen <= 1'b0;
      magnetron_on   <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      sec_ones       <= so_nxt;
      sec_tens       <= st_nxt;
      min_ones       <= mo_nxt;
      keypad_enablen <= (state_nxt != ST_ENTRY);
      magnetron_on   <= (state_nxt == ST_RUN);
      done           <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Purpose : directed-vector bench for countdown_timer with a queued scoreboard.
// Latency : expectations are queued after the stimulus edge and checked at the following falling edge.
// Backpress: none; the monitor drains every queued expectation each falling edge.
module tb_countdown_timer;

  logic       clk;
  logic       clearn;
  logic [3:0] bcd_in;
  logic       loadn;
  logic       startn;
  logic       stopn;
  logic       pgt_1hz;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       keypad_enablen;
  logic       magnetron_on;
  logic       done;

  typedef struct packed {
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    logic       kp;
    logic       mag;
    logic       dn;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  countdown_timer #(.DIGIT_W(4)) dut (
    .clk            (clk),
    .clearn         (clearn),
    .bcd_in         (bcd_in),
    .loadn          (loadn),
    .startn         (startn),
    .stopn          (stopn),
    .pgt_1hz        (pgt_1hz),
    .sec_ones       (sec_ones),
    .sec_tens       (sec_tens),
    .min_ones       (min_ones),
    .keypad_enablen (keypad_enablen),
    .magnetron_on   (magnetron_on),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops and compares everything queued, sampling on the falling edge.
  initial begin
    obs_t  e;
    obs_t  a;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{mo: min_ones, st: sec_tens, so: sec_ones,
               kp: keypad_enablen, mag: magnetron_on, dn: done};
        n_vec++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %0h:%0h%0h kp=%b mag=%b done=%b, want %0h:%0h%0h kp=%b mag=%b done=%b",
                   nm, a.mo, a.st, a.so, a.kp, a.mag, a.dn, e.mo, e.st, e.so, e.kp, e.mag, e.dn);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] mo, input logic [3:0] st,
                     input logic [3:0] so, input logic kp, input logic mag, input logic dn);
    exp_q.push_back('{mo: mo, st: st, so: so, kp: kp, mag: mag, dn: dn});
    name_q.push_back(nm);
  endtask

  task automatic strobe(input logic [3:0] d);
    bcd_in = d;
    loadn  = 1'b0;
    step();
    loadn  = 1'b1;
    step();
  endtask

  task automatic tick_p(input int n = 1);
    repeat (n) begin
      pgt_1hz = 1'b1;
      step();
      pgt_1hz = 1'b0;
      step();
    end
  endtask

  task automatic stop_p();
    stopn = 1'b0;
    step();
    stopn = 1'b1;
    step();
  endtask

  task automatic start_p();
    startn = 1'b0;
    step();
    startn = 1'b1;
    step();
  endtask

  initial begin
    clearn  = 1'b0;
    bcd_in  = 4'd0;
    loadn   = 1'b1;
    startn  = 1'b1;
    stopn   = 1'b1;
    pgt_1hz = 1'b0;
    step(2);
    chk("reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    clearn = 1'b1;
    step(2);
    chk("post_reset_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Digit entry 1,3,0.
    strobe(4'd1); strobe(4'd3); strobe(4'd0);
    chk("entry_130", 4'd1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    stop_p();
    chk("entry_stop_clear", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // 1:00 full minute countdown.
    strobe(4'd1); strobe(4'd0); strobe(4'd0);
    start_p();
    chk("start_100", 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    tick_p();
    chk("tick_059", 4'd0, 4'd5, 4'd9, 1'b1, 1'b1, 1'b0);
    tick_p(58);
    chk("tick_001", 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0);
    tick_p();
    chk("done_000", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    start_p();
    chk("done_to_entry", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Invalid digit and long strobe.
    strobe(4'd12);
    chk("bcd12_ignored", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    strobe(4'd7);
    chk("bcd7_shift", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0);
    bcd_in = 4'd3;
    loadn  = 1'b0;
    step(20);
    chk("long_strobe_one_shift", 4'd0, 4'd7, 4'd3, 1'b0, 1'b0, 1'b0);
    loadn = 1'b1;
    step();

    // Pause / resume / abort.
    stop_p();
    strobe(4'd5);
    start_p();
    tick_p(2);
    chk("run_003", 4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0);
    stop_p();
    chk("pause_003", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    tick_p(2);
    chk("pause_ticks_ignored", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    start_p();
    chk("resume_run", 4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0);
    stop_p();
    stop_p();
    chk("pause_stop_entry", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Start at zero time; tick coinciding with stop.
    start_p();
    chk("start_zero_ignored", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    strobe(4'd2);
    start_p();
    pgt_1hz = 1'b1;
    stopn   = 1'b0;
    step();
    chk("tick_stop_same_edge", 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    pgt_1hz = 1'b0;
    stopn   = 1'b1;
    step();

    // Async reset mid-run at 0:42, released with pgt_1hz high.
    stop_p();
    strobe(4'd4); strobe(4'd2);
    start_p();
    chk("run_042", 4'd0, 4'd4, 4'd2, 1'b1, 1'b1, 1'b0);
    step();
    clearn  = 1'b0;
    pgt_1hz = 1'b1;
    chk("async_reset_mid_run", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    clearn = 1'b1;
    strobe(4'd1);
    start_p();
    chk("no_tick_after_reset", 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0);
    pgt_1hz = 1'b0;
    step();
    pgt_1hz = 1'b1;
    step();
    chk("first_real_tick_done", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    pgt_1hz = 1'b0;
    step();

    // Unnormalised 0:99 counts as plain BCD.
    start_p();
    strobe(4'd9); strobe(4'd9);
    chk("entry_099", 4'd0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    start_p();
    tick_p(10);
    chk("count_089", 4'd0, 4'd8, 4'd9, 1'b1, 1'b1, 1'b0);

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_fail++;
        $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Receiving end of the keypad encoder path. Accepts BCD digits strobed by the encoder's `loadn`, shifts them into a three-digit M:SS display register, and counts the loaded time down to zero on the 1 Hz pulse while the magnetron is enabled. It also gates the encoder through `keypad_enablen`, so key entry is only accepted while the oven is idle.

## Interface
Parameters:
- `DIGIT_W`, default 4: BCD digit width. Fixed at 4; not to be overridden.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `clearn`  in  1  reset; asynchronous, active-low
- `bcd_in`  in  4  digit from encoder; valid when `loadn` falls
- `loadn`  in  1  encoder digit strobe, active-low; a falling edge means one digit
- `startn`  in  1  start button, active-low level
- `stopn`  in  1  stop/clear button, active-low; a falling edge is one event
- `pgt_1hz`  in  1  1 Hz timebase from divider; a rising edge is one tick
- `sec_ones`  out  4  seconds units digit
- `sec_tens`  out  4  seconds tens digit
- `min_ones`  out  4  minutes digit
- `keypad_enablen`  out  1  active-low enable to the encoder; 0 only in ENTRY
- `magnetron_on`  out  1  1 only in RUN
- `done`  out  1  1 only in DONE

## Operation
- Edge detectors: registered copies `loadn_q`, `stopn_q`, `pgt_q`.
  - `load_fall` = `loadn_q` & ~`loadn`
  - `stop_fall` = `stopn_q` & ~`stopn`
  - `tick` = ~`pgt_q` & `pgt_1hz`
- States: ENTRY, RUN, PAUSE, DONE.
- ENTRY:
  - On `load_fall` with `bcd_in` <= 9, shift left: `min_ones`<=`sec_tens`, `sec_tens`<=`sec_ones`, `sec_ones`<=`bcd_in`.
  - `bcd_in` 10–15 is ignored, with no shift.
  - `stop_fall` clears all digits to 0 and stays in ENTRY.
  - `startn`=0 with a nonzero time goes to RUN. `startn`=0 with time 000 is ignored.
- RUN:
  - On `tick`, apply a BCD decrement:
    - `sec_ones`>0: `sec_ones`-1.
    - Otherwise `sec_ones`=9 and `sec_tens`-1.
    - If `sec_tens` was also 0: `sec_tens`=5, `sec_ones`=9, `min_ones`-1.
  - The decrement that produces 000 moves the block to DONE on the same edge.
  - `stop_fall` goes to PAUSE with the digits held.
  - `load_fall` is ignored.
- PAUSE:
  - `startn`=0 goes to RUN.
  - `stop_fall` clears the digits and goes to ENTRY.
  - `tick` and `load_fall` are ignored.
- DONE:
  - Digits stay at 000.
  - `stop_fall` or `startn`=0 goes to ENTRY.
- Priority when events coincide:
  - In every state, `stop_fall` beats `startn`, which beats `tick`.
  - A `tick` coinciding with `stop_fall` in RUN does not decrement.
- Seconds tens above 5 is legal entry (e.g. 0:99). It counts down as plain BCD (99→98…→90→89…) with no normalization.

## Timing
- Reset (async, `clearn`=0):
  - state ENTRY
  - all digits 0
  - `keypad_enablen`=0, `magnetron_on`=0, `done`=0
  - `loadn_q`=`stopn_q`=`pgt_q`=1
- Reset preset of the edge registers: no spurious `load_fall`/`stop_fall` after reset while inputs idle high, and `pgt_1hz` held high at reset release gives no tick.
- Reset asserted mid-RUN forces the reset values immediately, independent of `clk`.
- Digit shift latency: the register updates on the first rising edge at which `loadn` samples 0 after sampling 1. Exactly one shift per strobe, however long `loadn` stays low.
- A tick decrements on the first edge at which `pgt_1hz` samples 1 after sampling 0. That is one decrement per 1 Hz period, regardless of the divider's duty cycle.
- Outputs are registered; state-derived outputs change on the same edge as the state.
- `startn` is level-sensitive. Holding it low through DONE→ENTRY re-enters RUN only if the time is nonzero, which it is not after DONE, so no restart occurs.

## Test plan
- Reset, then strobe digits 1,3,0 → `min_ones`=1, `sec_tens`=3, `sec_ones`=0; `keypad_enablen`=0.
- Enter 1,0,0, pulse `startn`, give 1 tick → 0:59; 59 further ticks → 000, `done`=1, `magnetron_on`=0.
- Strobe `bcd_in`=12, then 7 → only 7 is shifted in (0:07). Hold `loadn` low 20 cycles → only one shift occurs.
- Load 0:05, start, tick twice, `stop_fall` → PAUSE at 0:03. Ticks ignored. `startn` → RUN. A second `stop_fall` in PAUSE → ENTRY with 000.
- In ENTRY at 000, assert `startn` → stays in ENTRY, `magnetron_on`=0. In RUN, apply `tick` and `stop_fall` on the same edge → PAUSE with no decrement.
- Assert `clearn`=0 mid-RUN at 0:42 (between edges) → outputs go to 000, ENTRY immediately. Release with `pgt_1hz`=1 → no tick is counted.
